// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver and decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    localparam logic [7:0] CODE_E0    = 8'hE0;
    localparam logic [7:0] CODE_F0    = 8'hF0;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;

    // Set-2 arrow scan code to direction; anything else maps to DIR_NONE.
    function automatic dir_e arrow_dir(input logic [7:0] code);
        dir_e d;
        case (code)
            CODE_UP:    d = DIR_UP;
            CODE_DOWN:  d = DIR_DOWN;
            CODE_LEFT:  d = DIR_LEFT;
            CODE_RIGHT: d = DIR_RIGHT;
            default:    d = DIR_NONE;
        endcase
        return d;
    endfunction

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded key/direction event outputs of ps2_key_decoder.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       frame_err;
    logic [2:0] dir_out;

    modport master (
        output ps2_clk, ps2_data,
        input  key_valid, key_code, key_ext, key_break, frame_err, dir_out
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key_valid, key_code, key_ext, key_break, frame_err, dir_out
    );
endinterface

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 frame receiver: synchroniser, tick-sampled glitch filter, falling-edge
// strobe, 11-bit frame FSM and inter-edge watchdog. Strobes are valid in the cycle they fire.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int FILT_LEN      = 8,
    parameter int TIMEOUT_TICKS = 2500
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int WD_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_TICKS);

    logic [DIV_W-1:0]    div_q;
    logic [1:0]          clk_sync_q, data_sync_q;
    logic [FILT_LEN-1:0] clk_sh_q, data_sh_q;
    logic                clk_filt_q, data_filt_q, clk_prev_q;
    logic                tick_s, fall_s;

    frame_state_e        state_q, state_d;
    logic [2:0]          bitcnt_q, bitcnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic [WD_W-1:0]     wd_q, wd_d;

    assign tick_s = (div_q == DIV_LAST);
    assign fall_s = clk_prev_q & ~clk_filt_q;
    assign byte_o = shift_q;

    // Tick divider, synchronisers, glitch filters and edge-detect history.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_q       <= '0;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_sh_q    <= {FILT_LEN{1'b1}};
            data_sh_q   <= {FILT_LEN{1'b1}};
            clk_filt_q  <= 1'b1;
            data_filt_q <= 1'b1;
            clk_prev_q  <= 1'b1;
        end else begin
            div_q       <= tick_s ? '0 : div_q + 1'b1;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            if (tick_s) begin
                clk_sh_q  <= {clk_sh_q[FILT_LEN-2:0], clk_sync_q[1]};
                data_sh_q <= {data_sh_q[FILT_LEN-2:0], data_sync_q[1]};
            end
            if (&clk_sh_q)       clk_filt_q <= 1'b1;
            else if (~|clk_sh_q) clk_filt_q <= 1'b0;
            if (&data_sh_q)       data_filt_q <= 1'b1;
            else if (~|data_sh_q) data_filt_q <= 1'b0;
            clk_prev_q <= clk_filt_q;
        end
    end

    // Frame FSM and watchdog state registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wd_q     <= wd_d;
        end
    end

    // Next-state: bits are taken on the filtered falling edge; the watchdog
    // only runs inside a frame and is cleared by every edge.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        wd_d         = wd_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        if (fall_s) begin
            wd_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_filt_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d  = {data_filt_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = ST_PARITY;
                    else                  state_d = ST_DATA;
                end
                ST_PARITY: begin
                    par_d   = data_filt_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (data_filt_q && odd_parity_ok(shift_q, par_q)) byte_valid_o = 1'b1;
                    else                                              frame_err_o  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (wd_q == WD_LIMIT) begin
                frame_err_o = 1'b1;
                state_d     = ST_IDLE;
                wd_d        = '0;
            end else if (tick_s) begin
                wd_d = wd_q + 1'b1;
            end else begin
                wd_d = wd_q;
            end
        end else begin
            wd_d = '0;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder top: E0/F0 prefix resolution into key events, and an
// arrow-key tracker producing hold-qualified, optionally repeating direction pulses.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int FILT_LEN      = 8,
    parameter int TIMEOUT_TICKS = 2500,
    parameter int HOLD_CYCLES   = 2_000_000,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             clr,
    ps2_key_decoder_if.slave bus
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_MAX - 1);

    logic       rx_valid_s, rx_err_s;
    logic [7:0] rx_byte_s;

    ps2_rx_frame #(
        .CLK_DIV       (CLK_DIV),
        .FILT_LEN      (FILT_LEN),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_rx (
        .clk          (clk),
        .clr          (clr),
        .ps2_clk_i    (bus.ps2_clk),
        .ps2_data_i   (bus.ps2_data),
        .byte_valid_o (rx_valid_s),
        .byte_o       (rx_byte_s),
        .frame_err_o  (rx_err_s)
    );

    logic        ext_q, ext_d, brk_q, brk_d;
    logic        key_valid_q, key_valid_d, key_ext_q, key_ext_d, key_break_q, key_break_d;
    logic [7:0]  key_code_q, key_code_d;
    logic        frame_err_q, frame_err_d;
    dir_e        held_q, held_d, dir_q, dir_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic        fired_q, fired_d;
    logic        prefix_s, arrow_evt_s, evt_clear_s, evt_new_s;
    dir_e        ev_dir_s;

    assign prefix_s    = (rx_byte_s == CODE_E0) || (rx_byte_s == CODE_F0);
    assign ev_dir_s    = arrow_dir(rx_byte_s);
    assign arrow_evt_s = rx_valid_s && !prefix_s && ext_q && (ev_dir_s != DIR_NONE);
    assign evt_clear_s = arrow_evt_s && brk_q && (ev_dir_s == held_q);
    assign evt_new_s   = arrow_evt_s && !brk_q && (ev_dir_s != held_q);

    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_ext   = key_ext_q;
    assign bus.key_break = key_break_q;
    assign bus.frame_err = frame_err_q;
    assign bus.dir_out   = dir_q;

    // Prefix flags and registered key-event outputs.
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        frame_err_d = rx_err_s;
        if (rx_err_s) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid_s) begin
            case (rx_byte_s)
                CODE_E0: ext_d = 1'b1;
                CODE_F0: brk_d = 1'b1;
                default: begin
                    key_valid_d = 1'b1;
                    key_code_d  = rx_byte_s;
                    key_ext_d   = ext_q;
                    key_break_d = brk_q;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                end
            endcase
        end else begin
            key_valid_d = 1'b0;
        end
    end

    // Arrow tracker: an event in the same cycle as a due pulse overrides it;
    // a repeated make of the held arrow falls through and keeps counting.
    always_comb begin
        held_d     = held_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        fired_d    = fired_q;
        dir_d      = DIR_NONE;
        if (evt_clear_s) begin
            held_d     = DIR_NONE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            fired_d    = 1'b0;
        end else if (evt_new_s) begin
            held_d     = ev_dir_s;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            fired_d    = 1'b0;
        end else if (held_q == DIR_NONE) begin
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            fired_d    = 1'b0;
        end else if (!fired_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                dir_d   = held_q;
                fired_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end else if (REPEAT_CYCLES > 0) begin
            if (rep_cnt_q == REP_LAST) begin
                dir_d     = held_q;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end else begin
            rep_cnt_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            frame_err_q <= 1'b0;
            held_q      <= DIR_NONE;
            dir_q       <= DIR_NONE;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            fired_q     <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_break_q <= key_break_d;
            frame_err_q <= frame_err_d;
            held_q      <= held_d;
            dir_q       <= dir_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            fired_q     <= fired_d;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder: frames, prefixes, watchdog,
// glitch rejection, mid-frame reset and arrow hold/repeat timing.
module tb_ps2_key_decoder;

    localparam int H = 25;  // PS/2 half bit period in clk cycles

    logic clk = 1'b0;
    logic clr;
    ps2_key_decoder_if bus();

    ps2_key_decoder #(
        .CLK_DIV       (2),
        .FILT_LEN      (4),
        .TIMEOUT_TICKS (200),
        .HOLD_CYCLES   (100),
        .REPEAT_CYCLES (40)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int kv_n = 0, fe_n = 0, both_n = 0, dir_n = 0, kv_cyc = 0;
    logic [7:0] last_code = 8'h00;
    logic last_ext = 1'b0, last_brk = 1'b0;
    int dir_t [512];
    logic [2:0] dir_v [512];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.key_valid) begin
            kv_n      <= kv_n + 1;
            kv_cyc    <= cyc;
            last_code <= bus.key_code;
            last_ext  <= bus.key_ext;
            last_brk  <= bus.key_break;
        end
        if (bus.frame_err) fe_n <= fe_n + 1;
        if (bus.key_valid && bus.frame_err) both_n <= both_n + 1;
        if (bus.dir_out != 3'd0) begin
            if (dir_n < 512) begin
                dir_t[dir_n] <= cyc;
                dir_v[dir_n] <= bus.dir_out;
            end
            dir_n <= dir_n + 1;
        end
    end

    initial begin
        #800_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 800000 ns");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) @(posedge clk);
        #1;
    endtask

    // Drives the first nbits of an 11-bit frame; glitch_bit >= 0 adds a 2-clk low pulse on ps2_clk.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            if (i == glitch_bit) begin
                clk_wait(12);
                bus.ps2_clk = 1'b0;
                clk_wait(2);
                bus.ps2_clk = 1'b1;
                clk_wait(H - 14);
            end else begin
                clk_wait(H);
            end
            bus.ps2_clk = 1'b0;
            clk_wait(H);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b0, 11, -1);
    endtask

    int k0, f0, d0, kv1, kv2, t0, el, cnt;

    initial begin
        clr = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        clk_wait(5);
        chk("rst_key_valid", 32'(bus.key_valid), 32'd0);
        chk("rst_key_code",  32'(bus.key_code),  32'd0);
        chk("rst_ext_brk",   32'({bus.key_ext, bus.key_break}), 32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
        chk("rst_dir_out",   32'(bus.dir_out),   32'd0);
        clr = 1'b0;
        clk_wait(20);

        // Plain make code
        k0 = kv_n; f0 = fe_n;
        send_byte(8'h1C);
        chk("1c_kv_count", kv_n - k0, 1);
        chk("1c_code", 32'(last_code), 32'h1C);
        chk("1c_ext_brk", 32'({last_ext, last_brk}), 32'd0);
        chk("1c_no_err", fe_n - f0, 0);

        // Bad parity then recovery
        k0 = kv_n; f0 = fe_n;
        send_frame(8'h1C, 1'b1, 11, -1);
        chk("badpar_err", fe_n - f0, 1);
        chk("badpar_no_kv", kv_n - k0, 0);
        send_byte(8'h29);
        chk("recover_kv", kv_n - k0, 1);
        chk("recover_code", 32'(last_code), 32'h29);

        // Extended break with nothing held
        k0 = kv_n; d0 = dir_n;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        chk("e0f075_kv_count", kv_n - k0, 1);
        chk("e0f075_code", 32'(last_code), 32'h75);
        chk("e0f075_ext_brk", 32'({last_ext, last_brk}), 32'd3);
        clk_wait(200);
        chk("e0f075_no_dir", dir_n - d0, 0);

        // Up arrow held: pulses at +100, +140, +180
        d0 = dir_n;
        send_byte(8'hE0); send_byte(8'h75);
        kv1 = kv_cyc;
        chk("up_make_ext", 32'({last_code, last_ext, last_brk}), 32'({8'h75, 2'b10}));
        wait_until(kv1 + 190);
        chk("up_pulse_count", dir_n - d0, 3);
        chk("up_pulse0_time", dir_t[d0] - kv1, 100);
        chk("up_pulse1_time", dir_t[d0 + 1] - kv1, 140);
        chk("up_pulse2_time", dir_t[d0 + 2] - kv1, 180);
        chk("up_pulse_val", 32'(dir_v[d0]), 32'd1);

        // Typematic make of the same arrow keeps the repeat cadence
        send_byte(8'hE0); send_byte(8'h75);
        kv2 = kv_cyc;
        wait_until(kv2 + 99);
        cnt = 0;
        for (int i = 0; i < dir_n && i < 512; i++)
            if (dir_t[i] > kv2 && dir_t[i] < kv2 + 100) cnt++;
        chk("typematic_no_restart", 32'(cnt >= 2), 32'd1);

        // Break stops repeats
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        d0 = dir_n;
        clk_wait(300);
        chk("up_break_stops", dir_n - d0, 0);

        // Watchdog: clock stops after 5 data bits
        k0 = kv_n; f0 = fe_n;
        send_frame(8'h1C, 1'b0, 6, -1);
        t0 = cyc;
        for (int i = 0; i < 1000 && fe_n == f0; i++) @(negedge clk);
        el = cyc - t0 + H;
        chk("wd_err", fe_n - f0, 1);
        chk("wd_latency", 32'(el >= 400 && el <= 430), 32'd1);
        clk_wait(20);
        send_byte(8'h1C);
        chk("wd_recover_kv", kv_n - k0, 1);
        chk("wd_recover_code", 32'(last_code), 32'h1C);

        // Glitch on ps2_clk mid-bit
        k0 = kv_n; f0 = fe_n;
        send_frame(8'h5A, 1'b0, 11, 4);
        chk("glitch_kv", kv_n - k0, 1);
        chk("glitch_code", 32'(last_code), 32'h5A);
        chk("glitch_no_err", fe_n - f0, 0);

        // Newer arrow replaces the held one
        send_byte(8'hE0); send_byte(8'h72);
        send_byte(8'hE0); send_byte(8'h74);
        kv2 = kv_cyc;
        wait_until(kv2 + 105);
        chk("replace_prev_dir", 32'(dir_v[dir_n - 2]), 32'd2);
        chk("replace_new_dir", 32'(dir_v[dir_n - 1]), 32'd4);
        chk("replace_time", dir_t[dir_n - 1] - kv2, 100);
        d0 = dir_n;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
        clk_wait(45);
        chk("other_break_ignored", 32'(dir_n > d0 && cyc - dir_t[dir_n - 1] <= 41), 32'd1);
        chk("other_break_dir", 32'(dir_v[dir_n - 1]), 32'd4);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        d0 = dir_n;
        clk_wait(200);
        chk("right_break_stops", dir_n - d0, 0);

        // clr mid-frame aborts silently
        k0 = kv_n; f0 = fe_n;
        send_frame(8'hAA, 1'b0, 4, -1);
        clr = 1'b1;
        clk_wait(3);
        chk("midclr_code", 32'(bus.key_code), 32'd0);
        clr = 1'b0;
        clk_wait(500);
        chk("midclr_no_err", fe_n - f0, 0);
        send_byte(8'h1C);
        chk("midclr_recover", 32'({kv_n - k0, 24'(last_code)}), 32'({8'd1, 24'h1C}));

        chk("kv_fe_never_both", both_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
